// File: rtl/readout_ctrl.sv
// Column readout sequencer: steps the mux select, waits for the settle window,
// captures sub_out and streams one pixel per column. Optional READOUT_BLACK_LEVEL_EN.
module readout_ctrl #(
    parameter int mux_width     = 2,
    parameter int bus_width     = 8,
    parameter int settle_cycles = 2,
    parameter int black_level   = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    output logic [$clog2(mux_width)-1:0] select,
    input  logic [bus_width-1:0]         sub_out,
    output logic [bus_width-1:0]         pixel_data,
    output logic                         pixel_valid,
    input  logic                         pixel_ready,
    output logic [$clog2(mux_width)-1:0] col_idx,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   state_dbg
);

    localparam int SW = $clog2(mux_width);
    localparam int CW = (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(settle_cycles - 1);
    localparam logic [SW-1:0] SEL_LAST = SW'(mux_width - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_OUTPUT = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    if (mux_width < 2 || settle_cycles < 1 || black_level < 0) begin : g_param_check
        $error("readout_ctrl: illegal parameter value");
    end

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SW-1:0]        select_q, select_d;
    logic [SW-1:0]        col_idx_q, col_idx_d;
    logic [bus_width-1:0] pixel_data_q, pixel_data_d;
    logic                 pixel_valid_q, pixel_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [bus_width-1:0] capture_val;

`ifdef READOUT_BLACK_LEVEL_EN
    localparam logic [bus_width-1:0] BLACK = bus_width'(black_level);
    // Clamp at zero so dark pixels never wrap to bright values.
    assign capture_val = (sub_out > BLACK) ? sub_out - BLACK : '0;
`else
    assign capture_val = sub_out;
`endif

    // Stream handshake: a pixel transfers on a rising edge where pixel_valid and
    // pixel_ready are both high; once raised, pixel_valid, pixel_data and col_idx
    // hold until that transfer (or an abort/reset drops the pixel).
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        select_d      = select_q;
        col_idx_d     = col_idx_q;
        pixel_data_d  = pixel_data_q;
        pixel_valid_d = pixel_valid_q;
        done_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SETTLE;
                    select_d = '0;
                    cnt_d    = '0;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    pixel_data_d  = capture_val;
                    col_idx_d     = select_q;
                    pixel_valid_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (pixel_valid_q && pixel_ready) begin
                    pixel_valid_d = 1'b0;
                    if (select_q == SEL_LAST) begin
                        select_d = '0;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        select_d = select_q + 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort beats a same-cycle handshake: the pass ends with no done pulse.
        if (abort && state_q != ST_IDLE) begin
            state_d       = ST_IDLE;
            pixel_valid_d = 1'b0;
            select_d      = '0;
            cnt_d         = '0;
            done_d        = 1'b0;
        end

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_OUTPUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            select_q      <= '0;
            col_idx_q     <= '0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            select_q      <= select_d;
            col_idx_q     <= col_idx_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign select      = select_q;
    assign col_idx     = col_idx_q;
    assign pixel_data  = pixel_data_q;
    assign pixel_valid = pixel_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_readout_ctrl.sv
// Bench for readout_ctrl: mux/subtract environment model, expected-pixel queue
// filled at start, negedge monitor that pops and compares on every handshake.
module tb_readout_ctrl;

    localparam int MW = 2;
    localparam int BW = 8;
    localparam int SC = 2;
`ifdef READOUT_BLACK_LEVEL_EN
    localparam int BL = 190;
`else
    localparam int BL = 0;
`endif
    localparam int SW = $clog2(MW);
    localparam int EW = SW + BW;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [SW-1:0] select;
    logic [BW-1:0] sub_out;
    logic [BW-1:0] pixel_data;
    logic          pixel_valid;
    logic          pixel_ready;
    logic [SW-1:0] col_idx;
    logic          busy;
    logic          done;
    logic [1:0]    state_dbg;

    logic [BW-1:0] in1 [MW];
    logic [BW-1:0] in2 [MW];

    logic [EW-1:0] exp_q[$];
    int            exp_done;
    int            done_seen;
    int            n_checks;
    int            n_fail;
    int            cyc;
    int            ref_cyc;

    readout_ctrl #(
        .mux_width    (MW),
        .bus_width    (BW),
        .settle_cycles(SC),
        .black_level  (BL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .select     (select),
        .sub_out    (sub_out),
        .pixel_data (pixel_data),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .col_idx    (col_idx),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // Column muxes feeding the subtractor.
    assign sub_out = in1[select] - in2[select];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: CDS difference modulo 2^BW, optional saturating black-level offset.
    function automatic int model_pix(int c);
        int m;
        int raw;
        m   = 1 << BW;
        raw = ((int'(in1[c]) - int'(in2[c])) % m + m) % m;
`ifdef READOUT_BLACK_LEVEL_EN
        raw = (raw > BL) ? raw - BL : 0;
`endif
        return raw;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        for (int c = 0; c < MW; c++) begin
            exp_q.push_back({SW'(c), BW'(model_pix(c))});
        end
        exp_done++;
        start   = 1'b1;
        ref_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic drop_pass();
        exp_q.delete();
        exp_done--;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check("done_within_budget", int'(done), 1);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!pixel_valid && n < budget) begin
            tick();
            n++;
        end
        check("valid_within_budget", int'(pixel_valid), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, int'(pixel_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_select"}, int'(select), 0);
    endtask

    task automatic set_basic_inputs();
        in1[0] = 8'd85;
        in1[1] = 8'd200;
        in2[0] = 8'd157;
        in2[1] = 8'd255;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic          prev_valid;
        logic          prev_ready;
        logic          prev_abort;
        logic          prev_done;
        logic [BW-1:0] prev_data;
        logic [SW-1:0] prev_col;
        logic [SW-1:0] prev_sel;
        logic [EW-1:0] e;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_abort = 1'b0;
        prev_done  = 1'b0;
        prev_data  = '0;
        prev_col   = '0;
        prev_sel   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (pixel_valid && !prev_valid) begin
                    check("pixel_latency", cyc - ref_cyc, SC + 1);
                end
                if (prev_valid && !prev_ready && !prev_abort) begin
                    check("stall_valid", int'(pixel_valid), 1);
                    check("stall_data", int'(pixel_data), int'(prev_data));
                    check("stall_col", int'(col_idx), int'(prev_col));
                    check("stall_select", int'(select), int'(prev_sel));
                end
                if (pixel_valid) begin
                    check("col_matches_select", int'(col_idx), int'(select));
                end
                if (pixel_valid && pixel_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pixel_count", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel_data", int'(pixel_data), int'(e[BW-1:0]));
                        check("pixel_col", int'(col_idx), int'(e[EW-1:BW]));
                    end
                    ref_cyc = cyc;
                end
                if (done) begin
                    done_seen++;
                    check("done_after_last_pixel", exp_q.size(), 0);
                    check("done_single_cycle", int'(prev_done), 0);
                    check("busy_low_in_done", int'(busy), 0);
                end
                prev_valid = pixel_valid;
                prev_ready = pixel_ready;
                prev_abort = abort;
                prev_done  = done;
                prev_data  = pixel_data;
                prev_col   = col_idx;
                prev_sel   = select;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int abort_at;
        bit aborted;
        n_checks    = 0;
        n_fail      = 0;
        exp_done    = 0;
        done_seen   = 0;
        ref_cyc     = 0;
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        pixel_ready = 1'b0;
        set_basic_inputs();
        #1;
        check("rst_pixel_data", int'(pixel_data), 0);
        check("rst_col_idx", int'(col_idx), 0);
        check_idle_outputs("rst");
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_idle_outputs("post_rst");

        // Reset mid-SETTLE of column 1, after column 0 has been captured.
        pixel_ready = 1'b1;
        do_start();
        repeat (3) tick();
        check("pre_rst_busy", int'(busy), 1);
        check("pre_rst_select", int'(select), 1);
        reset = 1'b1;
        #1;
        check("midrst_pixel_data", int'(pixel_data), 0);
        check("midrst_col_idx", int'(col_idx), 0);
        check_idle_outputs("midrst");
        drop_pass();
        tick();
        reset = 1'b0;
        repeat (4) begin
            tick();
            check_idle_outputs("rst_release");
        end

        // Basic pass with ready tied high.
        do_start();
        n = 0;
        while (!done && n < 20) begin
            check("busy_during_pass", int'(busy), 1);
            tick();
            n++;
        end
        check("basic_done", int'(done), 1);
        tick();
        check_idle_outputs("basic_after");

        // Backpressure on column 0.
        pixel_ready = 1'b0;
        do_start();
        wait_valid(20);
        repeat (5) begin
            check("bp_data_held", int'(pixel_data), model_pix(0));
            check("bp_select_held", int'(select), 0);
            tick();
        end
        pixel_ready = 1'b1;
        wait_done(20);
        tick();

        // Abort while column 0 is on the output with ready high.
        do_start();
        wait_valid(20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        drop_pass();
        repeat (6) begin
            check_idle_outputs("abort_after");
            tick();
        end
        do_start();
        wait_done(20);
        tick();

        // Starts while busy and in the DONE cycle are ignored.
        do_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) begin
            check_idle_outputs("ign_start");
            tick();
        end

        // Randomized passes with random backpressure and occasional aborts.
        for (int p = 0; p < 30; p++) begin
            for (int c = 0; c < MW; c++) begin
                in1[c] = BW'($urandom_range(0, (1 << BW) - 1));
                in2[c] = BW'($urandom_range(0, (1 << BW) - 1));
            end
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
            aborted  = 1'b0;
            pixel_ready = ($urandom_range(0, 3) != 0);
            do_start();
            for (int k = 0; k < 200; k++) begin
                if (done) break;
                if (k == abort_at && busy) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    drop_pass();
                    aborted = 1'b1;
                    check_idle_outputs("rand_abort");
                    break;
                end
                if ($urandom_range(0, 7) == 0) start = 1'b1;
                pixel_ready = ($urandom_range(0, 3) != 0);
                tick();
                start = 1'b0;
            end
            if (!aborted) begin
                check("rand_done", int'(done), 1);
                tick();
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (5) tick();
        check("queue_drained", exp_q.size(), 0);
        check("done_pulse_count", done_seen, exp_done);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
